// File: rtl/bit_stream_serializer.sv
// Purpose: word-to-bit serializer feeding the BBCBC pattern detector (d_o=1 is B, d_o=0 is C).
// Latency: a word accepted at edge k puts its first bit on d_o with valid_o=1 in the cycle after edge k.
// Backpressure: wready_o drops while a pending word is held or flush_i is high; the bit stream itself never stalls
//   unless SER_PAUSE_EN is defined, which adds pause_i to hold the shifter.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wdata_i/wvalid_i    input word and its valid; wready_o accepts it on wvalid_i && wready_o
//   flush_i             synchronous discard of the in-flight and pending words
//   pause_i             (SER_PAUSE_EN only) freezes the shifter and counter
//   d_o/valid_o         serial bit and its qualifier
//   busy_o              shifter active or a pending word held
// Configuration macro: SER_PAUSE_EN (undefined by default).

module bit_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic             flush_i,
`ifdef SER_PAUSE_EN
  input  logic             pause_i,
`endif
  output logic             d_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // One-hot style encoding leaves illegal codes (00, 11) that fall back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] pend_q,  pend_d;
  logic             pend_full_q, pend_full_d;

  logic             pause;
  logic             shifting;
  logic             advance;
  logic             accept;
  logic             wready;
  logic             cur_bit;
  logic [WIDTH-1:0] shreg_shifted;

`ifdef SER_PAUSE_EN
  assign pause = pause_i;
`else
  assign pause = 1'b0;
`endif

  assign shifting = (state_q == S_SHIFT);
  // A bit is consumed on every valid cycle; pause is the only thing that stops it.
  assign advance  = shifting && !pause;
  assign wready   = !pend_full_q && !flush_i;
  assign accept   = wvalid_i && wready;

  // The bit on d_o always sits at the output end of shreg; shifting moves the next one in.
  assign cur_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;

    if (flush_i) begin
      // Flush outranks every transition and drops both words.
      state_d     = S_IDLE;
      shreg_d     = '0;
      cnt_d       = '0;
      pend_full_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shreg_d = wdata_i;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (!advance) begin
            // Paused: shifter and counter hold, but the pending slot still fills.
            if (accept) begin
              pend_d      = wdata_i;
              pend_full_d = 1'b1;
            end
          end else if (cnt_q != LAST_IDX) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + CW'(1);
            if (accept) begin
              pend_d      = wdata_i;
              pend_full_d = 1'b1;
            end
          end else begin
            // Last bit: chain straight into the next word so there is no gap.
            // accept cannot coincide with a pend drain since wready is low while pend_full.
            if (pend_full_q) begin
              shreg_d     = pend_q;
              cnt_d       = '0;
              pend_full_d = 1'b0;
            end else if (accept) begin
              shreg_d = wdata_i;
              cnt_d   = '0;
            end else begin
              state_d = S_IDLE;
              shreg_d = '0;
              cnt_d   = '0;
            end
          end
        end

        default: begin
          state_d     = S_IDLE;
          shreg_d     = '0;
          cnt_d       = '0;
          pend_full_d = 1'b0;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    wready_o = wready;
    valid_o  = shifting && !pause;
    d_o      = shifting ? cur_bit : 1'b0;
    busy_o   = shifting || pend_full_q;
  end

endmodule

// File: tb/tb_bit_stream_serializer.sv
module tb_bit_stream_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata;
  logic       wvalid;
  logic       flush;
  logic       pause;
  logic       wready, d, valid, busy;

  logic [7:0] wdata_l;
  logic       wvalid_l;
  logic       wready_l, d_l, valid_l, busy_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wdata_i  (wdata),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .flush_i  (flush),
`ifdef SER_PAUSE_EN
    .pause_i  (pause),
`endif
    .d_o      (d),
    .valid_o  (valid),
    .busy_o   (busy)
  );

  bit_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wdata_i  (wdata_l),
    .wvalid_i (wvalid_l),
    .wready_o (wready_l),
    .flush_i  (1'b0),
`ifdef SER_PAUSE_EN
    .pause_i  (1'b0),
`endif
    .d_o      (d_l),
    .valid_o  (valid_l),
    .busy_o   (busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word to the MSB-first instance for exactly one accepting edge.
  task automatic send(input logic [7:0] w);
    wdata  = w;
    wvalid = 1'b1;
    step();
    wvalid = 1'b0;
  endtask

  // Check n contiguous valid bits on the MSB-first instance, one per cycle.
  task automatic expect_stream(input string tag, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.valid[%0d]", tag, i), 32'(valid), 32'd1);
      chk($sformatf("%s.d[%0d]", tag, i), 32'(d), 32'(bits[n-1-i]));
      step();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    wdata    = '0;
    wvalid   = 1'b0;
    flush    = 1'b0;
    pause    = 1'b0;
    wdata_l  = '0;
    wvalid_l = 1'b0;

    // Reset values
    #3;
    chk("rst.valid", 32'(valid), 0);
    chk("rst.d", 32'(d), 0);
    chk("rst.wready", 32'(wready), 1);
    chk("rst.busy", 32'(busy), 0);
    #4 rst_n = 1'b1;
    step();

    // 1: single word D4 -> 1,1,0,1,0,1,0,0 then idle
    send(8'hD4);
    expect_stream("t1", 32'hD4, 8);
    chk("t1.valid_end", 32'(valid), 0);
    chk("t1.busy_end", 32'(busy), 0);
    step();

    // 2: A5 then 3C back-to-back, second lands in the pending slot
    wdata  = 8'hA5;
    wvalid = 1'b1;
    step();
    wdata = 8'h3C;
    #1;
    chk("t2.wready_c0", 32'(wready), 1);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp16;
      exp16 = 16'hA53C;
      chk($sformatf("t2.valid[%0d]", i), 32'(valid), 1);
      chk($sformatf("t2.d[%0d]", i), 32'(d), 32'(exp16[15-i]));
      if (i == 1 || i == 7) chk($sformatf("t2.wready[%0d]", i), 32'(wready), 0);
      if (i == 1) chk("t2.busy_pend", 32'(busy), 1);
      if (i == 8) chk("t2.wready[8]", 32'(wready), 1);
      step();
      wvalid = 1'b0;
    end
    chk("t2.valid_end", 32'(valid), 0);
    chk("t2.busy_end", 32'(busy), 0);
    step();

    // 2b: second word offered only on the last bit loads directly, no gap
    send(8'h81);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] exp16;
      exp16 = 16'h817E;
      chk($sformatf("t2b.valid[%0d]", i), 32'(valid), 1);
      chk($sformatf("t2b.d[%0d]", i), 32'(d), 32'(exp16[15-i]));
      if (i == 7) begin
        wdata  = 8'h7E;
        wvalid = 1'b1;
        #1;
        chk("t2b.wready_last", 32'(wready), 1);
      end
      step();
      wvalid = 1'b0;
    end
    chk("t2b.valid_end", 32'(valid), 0);
    step();

    // 3: LSB-first instance, 01 then D4
    wdata_l  = 8'h01;
    wvalid_l = 1'b1;
    step();
    wvalid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3a.valid[%0d]", i), 32'(valid_l), 1);
      chk($sformatf("t3a.d[%0d]", i), 32'(d_l), (i == 0) ? 32'd1 : 32'd0);
      step();
    end
    chk("t3a.valid_end", 32'(valid_l), 0);
    wdata_l  = 8'hD4;
    wvalid_l = 1'b1;
    step();
    wvalid_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'hD4;
      chk($sformatf("t3b.d[%0d]", i), 32'(d_l), 32'(e[i]));
      step();
    end
    chk("t3b.busy_end", 32'(busy_l), 0);

    // 4: flush at bit index 3 with a pending word
    wdata  = 8'hA5;
    wvalid = 1'b1;
    step();
    wdata = 8'h3C;
    step();
    wvalid = 1'b0;
    step();
    step();
    chk("t4.busy_pre", 32'(busy), 1);
    chk("t4.d_bit3", 32'(d), 0);
    flush = 1'b1;
    #1;
    chk("t4.wready_flush", 32'(wready), 0);
    step();
    flush = 1'b0;
    #1;
    chk("t4.valid", 32'(valid), 0);
    chk("t4.busy", 32'(busy), 0);
    chk("t4.wready", 32'(wready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4.quiet[%0d]", i), 32'(valid), 0);
    end

    // 5: reset during bit 5, then a fresh word starts at bit 0
    send(8'hD4);
    for (int i = 0; i < 5; i++) step();
    chk("t5.valid_pre", 32'(valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t5.valid", 32'(valid), 0);
    chk("t5.wready", 32'(wready), 1);
    chk("t5.busy", 32'(busy), 0);
    chk("t5.d", 32'(d), 0);
    #1 rst_n = 1'b1;
    step();
    chk("t5.idle", 32'(valid), 0);
    send(8'h96);
    expect_stream("t5", 32'h96, 8);
    chk("t5.valid_end", 32'(valid), 0);

`ifdef SER_PAUSE_EN
    // 6: pause two cycles at bit 4; word takes 10 cycles
    step();
    send(8'hD4);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] e;
      int         bi;
      e  = 8'hD4;
      pause = (i == 4 || i == 5);
      bi = (i < 4) ? i : ((i < 6) ? 4 : i - 2);
      #1;
      chk($sformatf("t6.valid[%0d]", i), 32'(valid), pause ? 32'd0 : 32'd1);
      chk($sformatf("t6.d[%0d]", i), 32'(d), 32'(e[7-bi]));
      step();
    end
    pause = 1'b0;
    #1;
    chk("t6.valid_end", 32'(valid), 0);
    chk("t6.busy_end", 32'(busy), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
